// File: rtl/ibuf_issue_unpack.sv
// Unpacks 2-slot instruction buffer entries onto two in-order decode lanes.
// Hold registers carry the pending slots; state is the number of pending slots.
module ibuf_issue_unpack #(
  parameter int unsigned SLOT_W  = 181,
  parameter int unsigned ENTRY_W = 2 * SLOT_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic [ENTRY_W-1:0] i_fifo_data,
  input  logic               i_fifo_empty,
  output logic               o_fifo_r_en,
  output logic               o_lane0_valid,
  output logic [SLOT_W-2:0]  o_lane0_data,
  output logic               o_lane1_valid,
  output logic [SLOT_W-2:0]  o_lane1_data,
  input  logic [1:0]         i_dec_accept
);

  localparam int unsigned PayW = SLOT_W - 1;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PayW-1:0]   lane0_q, lane0_d;
  logic [PayW-1:0]   lane1_q, lane1_d;

  logic [1:0]        count;
  logic [1:0]        eff_acc;
  logic [1:0]        remain;
  logic              pop;

  logic [SLOT_W-1:0] slot0;
  logic [SLOT_W-1:0] slot1;
  logic              slot0_v;
  logic              slot1_v;

  assign slot0   = i_fifo_data[SLOT_W-1:0];
  assign slot1   = i_fifo_data[ENTRY_W-1:SLOT_W];
  assign slot0_v = slot0[SLOT_W-1];
  assign slot1_v = slot1[SLOT_W-1];

  assign count   = (state_q == StTwo) ? 2'd2 : (state_q == StOne) ? 2'd1 : 2'd0;
  // Decode may claim more than is pending; clamp so the count never underflows.
  assign eff_acc = (i_dec_accept > count) ? count : i_dec_accept;
  assign remain  = count - eff_acc;

  // Gated by reset so an asserted reset never consumes the FIFO head.
  assign pop         = i_rst_n && !i_fifo_empty && !i_flush && (remain == 2'd0);
  assign o_fifo_r_en = pop;

  always_comb begin
    state_d = state_q;
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    if (i_flush) begin
      state_d = StEmpty;
      lane0_d = '0;
      lane1_d = '0;
    end else if (pop) begin
      if (slot0_v && slot1_v) begin
        state_d = StTwo;
        lane0_d = slot0[PayW-1:0];
        lane1_d = slot1[PayW-1:0];
      end else if (slot0_v) begin
        state_d = StOne;
        lane0_d = slot0[PayW-1:0];
        lane1_d = '0;
      end else if (slot1_v) begin
        state_d = StOne;
        lane0_d = slot1[PayW-1:0];
        lane1_d = '0;
      end else begin
        state_d = StEmpty;
        lane0_d = '0;
        lane1_d = '0;
      end
    end else if (remain == 2'd0) begin
      state_d = StEmpty;
      lane0_d = '0;
      lane1_d = '0;
    end else if (count == 2'd2 && eff_acc == 2'd1) begin
      state_d = StOne;
      lane0_d = lane1_q;
      lane1_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StEmpty;
      lane0_q <= '0;
      lane1_q <= '0;
    end else begin
      state_q <= state_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
    end
  end

  assign o_lane0_valid = (state_q == StOne) || (state_q == StTwo);
  assign o_lane1_valid = (state_q == StTwo);
  assign o_lane0_data  = o_lane0_valid ? lane0_q : '0;
  assign o_lane1_data  = o_lane1_valid ? lane1_q : '0;

endmodule

// File: tb/tb_ibuf_issue_unpack.sv
// Directed bench for ibuf_issue_unpack: inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_ibuf_issue_unpack;

  localparam int unsigned SlotW  = 181;
  localparam int unsigned EntryW = 362;
  localparam int unsigned PayW   = 180;

  localparam logic [PayW-1:0] PA = {20'hAAAAA, 160'h1};
  localparam logic [PayW-1:0] PB = {20'hBBBBB, 160'h2};
  localparam logic [PayW-1:0] PC = {20'hCCCCC, 160'h3};
  localparam logic [PayW-1:0] PD = {20'hDDDDD, 160'h4};
  localparam logic [PayW-1:0] PG = {20'h5A5A5, 160'hDEAD};

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [EntryW-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_r_en;
  logic              lane0_valid;
  logic [PayW-1:0]   lane0_data;
  logic              lane1_valid;
  logic [PayW-1:0]   lane1_data;
  logic [1:0]        dec_accept;

  int n_cmp;
  int n_err;

  ibuf_issue_unpack #(
    .SLOT_W (SlotW),
    .ENTRY_W(EntryW)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_r_en  (fifo_r_en),
    .o_lane0_valid(lane0_valid),
    .o_lane0_data (lane0_data),
    .o_lane1_valid(lane1_valid),
    .o_lane1_data (lane1_data),
    .i_dec_accept (dec_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PayW-1:0] obs, input logic [PayW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ren, input logic v0,
                            input logic [PayW-1:0] d0, input logic v1,
                            input logic [PayW-1:0] d1);
    #1;
    check({tag, ".r_en"}, PayW'(fifo_r_en), PayW'(ren));
    check({tag, ".v0"}, PayW'(lane0_valid), PayW'(v0));
    check({tag, ".d0"}, lane0_data, d0);
    check({tag, ".v1"}, PayW'(lane1_valid), PayW'(v1));
    check({tag, ".d1"}, lane1_data, d1);
  endtask

  task automatic drive(input logic empty, input logic [EntryW-1:0] data, input logic fl,
                       input logic [1:0] acc);
    fifo_empty = empty;
    fifo_data  = data;
    flush      = fl;
    dec_accept = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [EntryW-1:0] entry(input logic v1, input logic [PayW-1:0] p1,
                                              input logic v0, input logic [PayW-1:0] p0);
    return {v1, p1, v0, p0};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b1, '0, 1'b0, 2'd0);
    @(negedge clk);

    // 1: reset and idle after release
    expect_out("rst", 1'b0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b1;
    tick();
    expect_out("idle0", 1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    expect_out("idle1", 1'b0, 1'b0, '0, 1'b0, '0);

    // 2: back-to-back full entries at 2 slots/cycle
    drive(1'b0, entry(1'b1, PB, 1'b1, PA), 1'b0, 2'd0);
    expect_out("bb.pop1", 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, entry(1'b1, PD, 1'b1, PC), 1'b0, 2'd2);
    expect_out("bb.ab", 1'b1, 1'b1, PA, 1'b1, PB);
    tick();
    drive(1'b1, '0, 1'b0, 2'd2);
    expect_out("bb.cd", 1'b0, 1'b1, PC, 1'b1, PD);
    tick();
    expect_out("bb.empty", 1'b0, 1'b0, '0, 1'b0, '0);

    // 3: partial consumption, lane1 shifts down
    drive(1'b0, entry(1'b1, PB, 1'b1, PA), 1'b0, 2'd0);
    expect_out("part.pop", 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, entry(1'b1, PD, 1'b1, PC), 1'b0, 2'd1);
    expect_out("part.ab", 1'b0, 1'b1, PA, 1'b1, PB);
    tick();
    drive(1'b0, entry(1'b1, PD, 1'b1, PC), 1'b0, 2'd1);
    expect_out("part.b", 1'b1, 1'b1, PB, 1'b0, '0);
    tick();
    drive(1'b1, '0, 1'b0, 2'd0);
    expect_out("part.cd", 1'b0, 1'b1, PC, 1'b1, PD);
    tick();
    drive(1'b1, '0, 1'b0, 2'd2);
    expect_out("part.hold", 1'b0, 1'b1, PC, 1'b1, PD);
    tick();

    // 4: compaction of sparse entries
    drive(1'b0, entry(1'b1, PC, 1'b0, PG), 1'b0, 2'd0);
    expect_out("cmp.pop1", 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, entry(1'b0, PG, 1'b0, PG), 1'b0, 2'd1);
    expect_out("cmp.s1", 1'b1, 1'b1, PC, 1'b0, '0);
    tick();
    drive(1'b0, entry(1'b0, PG, 1'b1, PA), 1'b0, 2'd0);
    expect_out("cmp.none", 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b1, '0, 1'b0, 2'd1);
    expect_out("cmp.s0", 1'b0, 1'b1, PA, 1'b0, '0);
    tick();

    // 5: flush beats pop and accept
    drive(1'b0, entry(1'b1, PB, 1'b1, PA), 1'b0, 2'd0);
    tick();
    drive(1'b0, entry(1'b1, PD, 1'b1, PC), 1'b1, 2'd2);
    expect_out("fl.cycle", 1'b0, 1'b1, PA, 1'b1, PB);
    tick();
    drive(1'b0, entry(1'b1, PD, 1'b1, PC), 1'b0, 2'd0);
    expect_out("fl.after", 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b1, '0, 1'b0, 2'd1);
    expect_out("fl.cd", 1'b0, 1'b1, PC, 1'b1, PD);
    tick();

    // 6: over-accept in ONE clamps to 1 and pops
    drive(1'b0, entry(1'b1, PB, 1'b1, PA), 1'b0, 2'd2);
    expect_out("clamp.one", 1'b1, 1'b1, PD, 1'b0, '0);
    tick();
    drive(1'b0, entry(1'b1, PD, 1'b1, PC), 1'b0, 2'd0);
    expect_out("clamp.ab", 1'b0, 1'b1, PA, 1'b1, PB);
    tick();
    expect_out("clamp.hold", 1'b0, 1'b1, PA, 1'b1, PB);

    // Async reset mid-operation: outputs clear at once, no pop while held
    #2;
    rst_n = 1'b0;
    expect_out("arst", 1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    expect_out("arst.held", 1'b0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b1;
    expect_out("arst.rel", 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b1, '0, 1'b0, 2'd2);
    expect_out("arst.cd", 1'b0, 1'b1, PC, 1'b1, PD);
    tick();
    expect_out("end", 1'b0, 1'b0, '0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
